multicore_dispatch: RTL and testbench

MULTICORE_DISPATCH -- requirements
Module: multicore_dispatch

---
 rtl/multicore_pkg.sv | 19 +
 rtl/alu_core.sv | 104 ++++++++++
 rtl/multicore_dispatch.sv | 120 ++++++++++++
 tb/tb_multicore_dispatch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore dispatch block: op encodings,
// per-core state enum and the width of the multiply latency counter.
package multicore_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Wide enough for MUL_LAT-2 with MUL_LAT up to 8.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        CORE_IDLE = 2'b00,
        CORE_EXEC = 2'b01,
        CORE_DONE = 2'b10
    } core_state_t;

endpackage

// File: rtl/alu_core.sv
// Single ALU core: latches one request, runs it to completion and
// holds the result until the output arbiter grants it.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   CORE_IDLE | free, may accept a request
//   CORE_EXEC | multiply in flight, down-counter running
//   CORE_DONE | result valid, waiting for an arbiter grant
module alu_core
    import multicore_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               accept_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         op_i,
    input  logic               grant_i,
    output core_state_t        state_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               err_o
);

    // Cycles spent in EXEC after the first one; acceptance edge counts as one.
    localparam int MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    core_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2*WIDTH-1:0] a_ext, b_ext;

    // State, operand and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CORE_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a multiply with MUL_LAT=1 skips EXEC entirely.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            CORE_IDLE: begin
                if (accept_i) begin
                    a_d  = a_i;
                    b_d  = b_i;
                    op_d = op_i;
                    if (op_i == OP_MUL && MUL_LAT > 1) begin
                        state_d = CORE_EXEC;
                        cnt_d   = CNT_W'(MUL_CNT);
                    end else begin
                        state_d = CORE_DONE;
                    end
                end
            end
            CORE_EXEC: begin
                if (cnt_q == '0) state_d = CORE_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            CORE_DONE: begin
                if (grant_i) state_d = CORE_IDLE;
            end
            default: state_d = CORE_IDLE;
        endcase
    end

    assign a_ext = {{WIDTH{1'b0}}, a_q};
    assign b_ext = {{WIDTH{1'b0}}, b_q};

    // Datapath on the latched operands; the product of two zero-extended
    // WIDTH-bit values always fits in 2*WIDTH bits.
    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (op_q)
            OP_ADD:  result_o = a_ext + b_ext;
            OP_SUB:  result_o = a_ext - b_ext;
            OP_MUL:  result_o = a_ext * b_ext;
            default: err_o    = 1'b1;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/multicore_dispatch.sv
// Dispatches requests to NCORES independent ALU cores and collects their
// results through a round-robin arbiter into a single output register.
module multicore_dispatch
    import multicore_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCORES  = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          B,
    input  logic [1:0]                op,
    input  logic [$clog2(NCORES)-1:0] core_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [2*WIDTH-1:0]        result,
    output logic [$clog2(NCORES)-1:0] core_flag,
    output logic                      err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int IW = $clog2(NCORES);

    core_state_t        core_st  [NCORES];
    logic [2*WIDTH-1:0] core_res [NCORES];
    logic               core_err [NCORES];
    logic [NCORES-1:0]  grant;

    logic               accept;
    logic               any_done, load;
    logic [IW-1:0]      win, idx;

    logic [2*WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]      flag_q, flag_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic [IW-1:0]      ptr_q, ptr_d;

    assign in_ready = (core_st[core_sel] == CORE_IDLE);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        alu_core #(
            .WIDTH   (WIDTH),
            .MUL_LAT (MUL_LAT)
        ) u_core (
            .clk_i    (clk),
            .rst_ni   (rst),
            .accept_i (accept && (core_sel == IW'(i))),
            .a_i      (A),
            .b_i      (B),
            .op_i     (op),
            .grant_i  (grant[i]),
            .state_o  (core_st[i]),
            .result_o (core_res[i]),
            .err_o    (core_err[i])
        );
        assign grant[i] = load && (win == IW'(i));
    end

    // Round-robin search for the first DONE core starting at ptr_q.
    always_comb begin
        any_done = 1'b0;
        win      = '0;
        idx      = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = ptr_q + IW'(k);
            if (!any_done && core_st[idx] == CORE_DONE) begin
                any_done = 1'b1;
                win      = idx;
            end
        end
    end

    assign load = any_done && (!valid_q || out_ready);

    // Output register load/drain and pointer advance past the winner.
    always_comb begin
        result_d = result_q;
        flag_d   = flag_q;
        err_d    = err_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        if (load) begin
            result_d = core_res[win];
            flag_d   = win;
            err_d    = core_err[win];
            valid_d  = 1'b1;
            ptr_d    = win + IW'(1);
        end else if (out_ready) begin
            valid_d  = 1'b0;
        end
    end

    // Output stage and arbitration pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            flag_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            ptr_q    <= '0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign result    = result_q;
    assign core_flag = flag_q;
    assign err       = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_multicore_dispatch.sv
// Self-checking bench for multicore_dispatch (WIDTH=8, NCORES=4, MUL_LAT=2).
module tb_multicore_dispatch;

    typedef struct {
        logic [15:0] res;
        logic [1:0]  flag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  core;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  A, B;
    logic [1:0]  op, core_sel;
    logic        in_valid, in_ready;
    logic [15:0] result;
    logic [1:0]  core_flag;
    logic        err, out_valid, out_ready;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[8];

    multicore_dispatch #(.WIDTH(8), .NCORES(4), .MUL_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .op        (op),
        .core_sel  (core_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .core_flag (core_flag),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] c, input logic [1:0] o,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.flag = c;
        e.err  = 1'b0;
        case (o)
            2'b00:   e.res = 16'(a) + 16'(b);
            2'b01:   e.res = 16'(a) - 16'(b);
            2'b10:   e.res = 16'(a) * 16'(b);
            default: begin e.res = 16'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Scoreboard: every accepted output beat is matched against the queue head.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got res=%h flag=%0d err=%0b with nothing expected",
                         result, core_flag, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.res || core_flag !== e.flag || err !== e.err) begin
                    errors++;
                    $display("FAIL scoreboard: got res=%h flag=%0d err=%0b expected res=%h flag=%0d err=%0b",
                             result, core_flag, err, e.res, e.flag, e.err);
                end
            end
        end
    end

    // Drive one request; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] c, input logic [1:0] o,
                         input logic [7:0] a, input logic [7:0] b, input bit push);
        core_sel = c; op = o; A = a; B = b; in_valid = 1'b1;
        #1;
        chk("in_ready_at_issue", in_ready, 1);
        if (push) sb.push_back(model(c, o, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from acceptance until out_valid rises.
    task automatic wait_lat(input int exp_lat);
        int lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_complete", done, 1);
    endtask

    task automatic chk_all_ready(input string name);
        for (int k = 0; k < 4; k++) begin
            core_sel = 2'(k);
            #0.5;
            chk(name, in_ready, 1);
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 1};
        vecs[1] = '{2'd1, 2'b01, 8'd3,   8'd5,   16'hFFFE, 1'b0, 1};
        vecs[2] = '{2'd2, 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 2};
        vecs[3] = '{2'd3, 2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 1};
        vecs[4] = '{2'd0, 2'b10, 8'd0,   8'd77,  16'h0000, 1'b0, 2};
        vecs[5] = '{2'd1, 2'b11, 8'd9,   8'd9,   16'h0000, 1'b1, 1};
        vecs[6] = '{2'd3, 2'b01, 8'd100, 8'd1,   16'h0063, 1'b0, 1};
        vecs[7] = '{2'd2, 2'b10, 8'd16,  8'd16,  16'h0100, 1'b0, 2};

        rst = 1'b0; A = '0; B = '0; op = '0; core_sel = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_core_flag", core_flag, 0);
        chk("reset_err", err, 0);
        #11 rst = 1'b1;
        @(posedge clk); #1;
        chk_all_ready("in_ready_after_reset");

        // Table-driven single requests.
        foreach (vecs[i]) begin
            exp_t e;
            e.res = vecs[i].exp_res; e.flag = vecs[i].core; e.err = vecs[i].exp_err;
            sb.push_back(e);
            issue(vecs[i].core, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_lat(vecs[i].exp_lat);
        end
        drain();

        // Random single requests checked against the model.
        for (int i = 0; i < 6; i++) begin
            logic [1:0] c, o;
            c = 2'($urandom_range(0, 3));
            o = 2'($urandom_range(0, 3));
            issue(c, o, 8'($urandom), 8'($urandom), 1'b1);
            wait_lat(o == 2'b10 ? 2 : 1);
        end
        drain();

        // Granted core is busy during the grant cycle, free on the next one.
        issue(2'd0, 2'b00, 8'd1, 8'd2, 1'b1);
        chk("in_ready_during_grant", in_ready, 0);
        @(posedge clk); #1;
        chk("in_ready_after_grant", in_ready, 1);
        drain();

        // Four adds with output stalled, then held-output stability, then drain in order.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            issue(2'(k), 2'b00, 8'(10 * k + 1), 8'(k + 2), 1'b1);
        for (int k = 0; k < 4; k++) begin
            core_sel = 2'(k);
            #0.5;
            chk("in_ready_stalled", in_ready, (k == 0) ? 1 : 0);
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", result, 16'd3);
            chk("hold_core_flag", core_flag, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        chk_all_ready("in_ready_after_burst");

        // Mul on core 3 then add on core 0: add result emerges first.
        sb.push_back(model(2'd0, 2'b00, 8'd7, 8'd9));
        sb.push_back(model(2'd3, 2'b10, 8'd12, 8'd13));
        issue(2'd3, 2'b10, 8'd12, 8'd13, 1'b0);
        issue(2'd0, 2'b00, 8'd7, 8'd9, 1'b0);
        drain();
        issue(2'd1, 2'b11, 8'd55, 8'd66, 1'b1);
        wait_lat(1);
        chk("rsvd_err", err, 1);
        chk("rsvd_result", result, 0);
        drain();

        // Reset with core 1 in DONE and core 2 in EXEC.
        out_ready = 1'b0;
        issue(2'd0, 2'b00, 8'd5, 8'd5, 1'b0);
        issue(2'd1, 2'b01, 8'd9, 8'd4, 1'b0);
        issue(2'd2, 2'b10, 8'd20, 8'd30, 1'b0);
        chk("pre_reset_out_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_result", result, 0);
        chk("async_reset_core_flag", core_flag, 0);
        chk("async_reset_err", err, 0);
        sb.delete();
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        out_ready = 1'b1;
        chk_all_ready("in_ready_after_midrun_reset");
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("no_stale_output", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
